// File: rtl/issue_unit_pkg.sv
// Shared definitions for the issue unit: FU and operator codes, operand-select
// bit positions, issue-queue entry layout and the staging FSM state type.
package issue_unit_pkg;

  localparam int ISSUE_Q_WIDTH = 123;
  localparam int NUM_FU        = 4;
  localparam int NUM_REGS      = 32;
  localparam int REG_AW        = 5;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_LSU = 2'd1,
    FU_BPU = 2'd2,
    FU_CSR = 2'd3
  } fu_e;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_LD    = 4'd10,
    OP_ST    = 4'd11,
    OP_BEQ   = 4'd12,
    OP_BNE   = 4'd13,
    OP_JAL   = 4'd14,
    OP_CSRRW = 4'd15
  } operator_e;

  localparam int OPND_PC  = 0;
  localparam int OPND_IMM = 1;
  localparam int OPND_RS2 = 2;
  localparam int OPND_RS1 = 3;

  localparam int FUNC_LSB   = 0;
  localparam int FUNC_W     = 2;
  localparam int OPTR_LSB   = 2;
  localparam int OPTR_W     = 4;
  localparam int OPND_LSB   = 6;
  localparam int OPND_W     = 4;
  localparam int IMM_LSB    = 10;
  localparam int IMM_W      = 32;
  localparam int RS1_LSB    = 42;
  localparam int RS2_LSB    = 47;
  localparam int RD_LSB     = 52;
  localparam int RD_WEN_BIT = 57;
  localparam int TAKEN_BIT  = 58;
  localparam int NXT_PC_LSB = 59;
  localparam int CUR_PC_LSB = 91;
  localparam int PC_W       = 32;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_e;

  function automatic logic [NUM_FU-1:0] fu_onehot(input logic [FUNC_W-1:0] fu);
    return 4'b0001 << fu;
  endfunction

endpackage

// File: rtl/issue_unit_scoreboard.sv
// Register busy-bit scoreboard: one bit per architectural register, x0 never busy.
// A set and a clear of the same register in one cycle resolve as set.
module issue_scoreboard
  import issue_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] lkp_rs1_addr,
  input  logic [REG_AW-1:0] lkp_rs2_addr,
  input  logic [REG_AW-1:0] lkp_rd_addr,
  output logic              lkp_rs1_busy,
  output logic              lkp_rs2_busy,
  output logic              lkp_rd_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign lkp_rs1_busy = busy_q[lkp_rs1_addr];
  assign lkp_rs2_busy = busy_q[lkp_rs2_addr];
  assign lkp_rd_busy  = busy_q[lkp_rd_addr];

endmodule

// File: rtl/issue_unit.sv
// Single-entry issue stage: pops the issue queue, checks register hazards and
// dispatches one-hot to a functional unit. Option macro: ISSUE_UNIT_WB_BYPASS_EN.
module issue_unit #(
  parameter int ISSUE_Q_WIDTH = issue_unit_pkg::ISSUE_Q_WIDTH,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_q_rok,
  output logic                     issue_q_ren,
  input  logic [ISSUE_Q_WIDTH-1:0] issue_q_rdata,
  output logic [4:0]               rf_rs1_addr,
  output logic [4:0]               rf_rs2_addr,
  input  logic [DATA_WIDTH-1:0]    rf_rs1_data,
  input  logic [DATA_WIDTH-1:0]    rf_rs2_data,
  output logic [3:0]               disp_valid,
  input  logic [3:0]               disp_ready,
  output logic [3:0]               disp_operator,
  output logic [DATA_WIDTH-1:0]    disp_op1,
  output logic [DATA_WIDTH-1:0]    disp_op2,
  output logic [DATA_WIDTH-1:0]    disp_imm,
  output logic [4:0]               disp_rd,
  output logic                     disp_rd_wen,
  output logic [ADDR_WIDTH-1:0]    disp_cur_pc,
  output logic [ADDR_WIDTH-1:0]    disp_nxt_pc,
  output logic                     disp_taken,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     flush
);

  import issue_unit_pkg::*;

  state_e                   state_q, state_d;
  logic [ISSUE_Q_WIDTH-1:0] entry_q, entry_d;

  logic [FUNC_W-1:0] e_func;
  logic [OPTR_W-1:0] e_optr;
  logic [OPND_W-1:0] e_opnd;
  logic [IMM_W-1:0]  e_imm;
  logic [REG_AW-1:0] e_rs1, e_rs2, e_rd;
  logic              e_rd_wen, e_taken;
  logic [PC_W-1:0]   e_nxt_pc, e_cur_pc;

  assign e_func   = entry_q[FUNC_LSB +: FUNC_W];
  assign e_optr   = entry_q[OPTR_LSB +: OPTR_W];
  assign e_opnd   = entry_q[OPND_LSB +: OPND_W];
  assign e_imm    = entry_q[IMM_LSB +: IMM_W];
  assign e_rs1    = entry_q[RS1_LSB +: REG_AW];
  assign e_rs2    = entry_q[RS2_LSB +: REG_AW];
  assign e_rd     = entry_q[RD_LSB +: REG_AW];
  assign e_rd_wen = entry_q[RD_WEN_BIT];
  assign e_taken  = entry_q[TAKEN_BIT];
  assign e_nxt_pc = entry_q[NXT_PC_LSB +: PC_W];
  assign e_cur_pc = entry_q[CUR_PC_LSB +: PC_W];

  logic busy_rs1, busy_rs2, busy_rd;
  logic hit_rs1, hit_rs2, hit_rd;
  logic hazard, fire, pop, sb_set;
  logic [DATA_WIDTH-1:0] src1_data, src2_data;

  // A writeback landing this cycle counts as already retired for the hazard
  // check and supplies the operand directly.
`ifdef ISSUE_UNIT_WB_BYPASS_EN
  assign hit_rs1   = wb_valid & (wb_rd == e_rs1) & (e_rs1 != '0);
  assign hit_rs2   = wb_valid & (wb_rd == e_rs2) & (e_rs2 != '0);
  assign hit_rd    = wb_valid & (wb_rd == e_rd) & (e_rd != '0);
  assign src1_data = hit_rs1 ? wb_data : rf_rs1_data;
  assign src2_data = hit_rs2 ? wb_data : rf_rs2_data;
`else
  logic [DATA_WIDTH-1:0] unused_wb_data;
  assign hit_rs1        = 1'b0;
  assign hit_rs2        = 1'b0;
  assign hit_rd         = 1'b0;
  assign src1_data      = rf_rs1_data;
  assign src2_data      = rf_rs2_data;
  assign unused_wb_data = wb_data;
`endif

  assign hazard = (e_opnd[OPND_RS1] & busy_rs1 & ~hit_rs1)
                | (e_opnd[OPND_RS2] & busy_rs2 & ~hit_rs2)
                | (e_rd_wen & busy_rd & ~hit_rd);

  always_comb begin
    disp_valid = '0;
    if ((state_q == ST_HELD) && !hazard && !flush) disp_valid = fu_onehot(e_func);
  end

  assign fire        = |(disp_valid & disp_ready);
  assign issue_q_ren = ~flush & ((state_q == ST_EMPTY) | fire);
  assign pop         = issue_q_ren & issue_q_rok;
  assign sb_set      = fire & e_rd_wen & (e_rd != '0);

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    if (pop) entry_d = issue_q_rdata;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (state_q == ST_EMPTY) begin
      if (pop) state_d = ST_HELD;
    end else if (fire) begin
      state_d = pop ? ST_HELD : ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
    end
  end

  issue_scoreboard u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_en       (sb_set),
    .set_addr     (e_rd),
    .clr_en       (wb_valid),
    .clr_addr     (wb_rd),
    .lkp_rs1_addr (e_rs1),
    .lkp_rs2_addr (e_rs2),
    .lkp_rd_addr  (e_rd),
    .lkp_rs1_busy (busy_rs1),
    .lkp_rs2_busy (busy_rs2),
    .lkp_rd_busy  (busy_rd)
  );

  always_comb begin
    disp_op1 = '0;
    if (e_opnd[OPND_RS1])     disp_op1 = src1_data;
    else if (e_opnd[OPND_PC]) disp_op1 = DATA_WIDTH'(e_cur_pc);
    disp_op2 = '0;
    if (e_opnd[OPND_RS2])      disp_op2 = src2_data;
    else if (e_opnd[OPND_IMM]) disp_op2 = DATA_WIDTH'(e_imm);
  end

  assign rf_rs1_addr   = e_rs1;
  assign rf_rs2_addr   = e_rs2;
  assign disp_operator = e_optr;
  assign disp_imm      = DATA_WIDTH'(e_imm);
  assign disp_rd       = e_rd;
  assign disp_rd_wen   = e_rd_wen;
  assign disp_cur_pc   = ADDR_WIDTH'(e_cur_pc);
  assign disp_nxt_pc   = ADDR_WIDTH'(e_nxt_pc);
  assign disp_taken    = e_taken;

endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit: directed scenarios plus randomized traffic,
// all compared each cycle against a queue/array model of the issue stage.
module tb_issue_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         issue_q_rok;
  logic         issue_q_ren;
  logic [122:0] issue_q_rdata;
  logic [4:0]   rf_rs1_addr, rf_rs2_addr;
  logic [31:0]  rf_rs1_data, rf_rs2_data;
  logic [3:0]   disp_valid, disp_ready, disp_operator;
  logic [31:0]  disp_op1, disp_op2, disp_imm;
  logic [4:0]   disp_rd;
  logic         disp_rd_wen;
  logic [31:0]  disp_cur_pc, disp_nxt_pc;
  logic         disp_taken;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic         flush;

  always #5 clk = ~clk;

  issue_unit dut (
    .clk(clk), .rst_n(rst_n),
    .issue_q_rok(issue_q_rok), .issue_q_ren(issue_q_ren), .issue_q_rdata(issue_q_rdata),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_operator(disp_operator),
    .disp_op1(disp_op1), .disp_op2(disp_op2), .disp_imm(disp_imm),
    .disp_rd(disp_rd), .disp_rd_wen(disp_rd_wen),
    .disp_cur_pc(disp_cur_pc), .disp_nxt_pc(disp_nxt_pc), .disp_taken(disp_taken),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
  );

  // Environment and reference model state
  logic [31:0]  rf_m [32];
  bit           busy_m [32];
  logic [122:0] iq [$];
  logic [122:0] stq [$];

  assign rf_rs1_data = rf_m[rf_rs1_addr];
  assign rf_rs2_data = rf_m[rf_rs2_addr];

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0]  obs_valid;
  logic        obs_ren;
  logic [31:0] obs_op1, obs_op2, obs_imm;
  logic        obs_taken;

  bit byp;
  initial begin
    byp = 1'b0;
`ifdef ISSUE_UNIT_WB_BYPASS_EN
    byp = 1'b1;
`endif
  end

  localparam logic [3:0] R = 4'b1111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [122:0] mk(input int fu, input int op, input int opnd,
                                      input logic [31:0] imm, input int rs1, input int rs2,
                                      input int rd, input int wen, input int tk,
                                      input logic [31:0] npc, input logic [31:0] cpc);
    return {cpc, npc, 1'(tk), 1'(wen), 5'(rd), 5'(rs2), 5'(rs1), imm, 4'(opnd), 4'(op), 2'(fu)};
  endfunction

  function automatic logic [122:0] rand_entry();
    return mk($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15), $urandom,
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom);
  endfunction

  function automatic bit is_busy(input logic [4:0] r, input logic wbv, input logic [4:0] wbr);
    if (r == 5'd0) return 1'b0;
    if (byp && wbv && wbr == r) return 1'b0;
    return busy_m[r];
  endfunction

  function automatic logic [31:0] reg_val(input logic [4:0] r, input logic wbv,
                                          input logic [4:0] wbr, input logic [31:0] wbd);
    if (r == 5'd0) return 32'd0;
    if (byp && wbv && wbr == r) return wbd;
    return rf_m[r];
  endfunction

  // One clock of traffic: drive at negedge, compare, advance model after posedge.
  task automatic cycle(input logic [3:0] rdy, input logic fl = 1'b0, input logic wbv = 1'b0,
                       input logic [4:0] wbr = 5'd0, input logic [31:0] wbd = 32'd0);
    logic [122:0] e;
    logic [3:0]   ev;
    logic [31:0]  exp_op1, exp_op2;
    bit held, hz, fire_m, ren_m, pop_m;
    disp_ready    = rdy;
    flush         = fl;
    wb_valid      = wbv;
    wb_rd         = wbr;
    wb_data       = wbd;
    issue_q_rok   = (iq.size() != 0);
    issue_q_rdata = issue_q_rok ? iq[0] : '0;
    #1;
    held   = (stq.size() != 0);
    e      = held ? stq[0] : '0;
    hz     = held && ((e[9] && is_busy(e[46:42], wbv, wbr)) ||
                      (e[8] && is_busy(e[51:47], wbv, wbr)) ||
                      (e[57] && is_busy(e[56:52], wbv, wbr)));
    ev     = (held && !hz && !fl) ? (4'b0001 << e[1:0]) : 4'b0000;
    fire_m = |(ev & rdy);
    ren_m  = !fl && (!held || fire_m);
    pop_m  = ren_m && (iq.size() != 0);
    exp_op1 = e[9] ? reg_val(e[46:42], wbv, wbr, wbd) : (e[6] ? e[122:91] : 32'd0);
    exp_op2 = e[8] ? reg_val(e[51:47], wbv, wbr, wbd) : (e[7] ? e[41:10] : 32'd0);

    obs_valid = disp_valid;
    obs_ren   = issue_q_ren;
    obs_op1   = disp_op1;
    obs_op2   = disp_op2;
    obs_imm   = disp_imm;
    obs_taken = disp_taken;

    chk("disp_valid", disp_valid, ev);
    chk("issue_q_ren", issue_q_ren, ren_m);
    if (held) begin
      chk("rf_rs1_addr", rf_rs1_addr, e[46:42]);
      chk("rf_rs2_addr", rf_rs2_addr, e[51:47]);
    end
    if (ev != 4'b0000) begin
      chk("disp_operator", disp_operator, e[5:2]);
      chk("disp_op1", disp_op1, exp_op1);
      chk("disp_op2", disp_op2, exp_op2);
      chk("disp_imm", disp_imm, e[41:10]);
      chk("disp_rd", disp_rd, e[56:52]);
      chk("disp_rd_wen", disp_rd_wen, e[57]);
      chk("disp_taken", disp_taken, e[58]);
      chk("disp_nxt_pc", disp_nxt_pc, e[90:59]);
      chk("disp_cur_pc", disp_cur_pc, e[122:91]);
    end

    @(posedge clk);
    #1;
    if (wbv && wbr != 5'd0) begin
      busy_m[wbr] = 1'b0;
      rf_m[wbr]   = wbd;
    end
    if (fl) begin
      stq.delete();
    end else begin
      if (fire_m) begin
        if (e[57] && e[56:52] != 5'd0) busy_m[e[56:52]] = 1'b1;
        stq.delete();
      end
      if (pop_m) stq.push_back(iq.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, disp_valid, 4'b0000);
    chk({tag, "_ren"}, issue_q_ren, 1'b1);
    chk({tag, "_operator"}, disp_operator, 4'd0);
    chk({tag, "_op1"}, disp_op1, 32'd0);
    chk({tag, "_op2"}, disp_op2, 32'd0);
    chk({tag, "_imm"}, disp_imm, 32'd0);
    chk({tag, "_rd"}, disp_rd, 5'd0);
    chk({tag, "_rd_wen"}, disp_rd_wen, 1'b0);
    chk({tag, "_taken"}, disp_taken, 1'b0);
    chk({tag, "_cur_pc"}, disp_cur_pc, 32'd0);
    chk({tag, "_nxt_pc"}, disp_nxt_pc, 32'd0);
    chk({tag, "_rs1_addr"}, rf_rs1_addr, 5'd0);
    chk({tag, "_rs2_addr"}, rf_rs2_addr, 5'd0);
  endtask

  task automatic model_reset();
    iq.delete();
    stq.delete();
    for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
  endtask

  initial begin
    logic [3:0]  rdy;
    logic        wbv;
    logic [4:0]  wbr;
    int          cand [$];

    rst_n = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    disp_ready = '0; issue_q_rok = 1'b0; issue_q_rdata = '0;
    for (int r = 0; r < 32; r++) rf_m[r] = 32'(r * 11);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back independent ALU ops
    iq.push_back(mk(0, 0, 4'b1100, 32'd0, 2, 3, 1, 1, 0, 32'h104, 32'h100));
    iq.push_back(mk(0, 0, 4'b1010, 32'd7, 5, 0, 4, 1, 0, 32'h108, 32'h104));
    cycle(R);
    chk("b2b_first_pop_ren", obs_ren, 1'b1);
    chk("b2b_first_pop_valid", obs_valid, 4'b0000);
    cycle(R);
    chk("b2b_add_valid", obs_valid, 4'b0001);
    chk("b2b_add_op1", obs_op1, 32'd22);
    chk("b2b_add_op2", obs_op2, 32'd33);
    cycle(R);
    chk("b2b_addi_valid", obs_valid, 4'b0001);
    chk("b2b_addi_op1", obs_op1, 32'd55);
    chk("b2b_addi_op2", obs_op2, 32'd7);

    // RAW hazard on x1
    iq.push_back(mk(0, 1, 4'b1100, 32'd0, 1, 2, 6, 1, 0, 32'h10c, 32'h108));
    cycle(R);
    repeat (3) begin
      cycle(R);
      chk("raw_held_valid", obs_valid, 4'b0000);
    end
    cycle(R, 1'b0, 1'b1, 5'd1, 32'h1234);
`ifdef ISSUE_UNIT_WB_BYPASS_EN
    chk("raw_bypass_valid", obs_valid, 4'b0001);
    chk("raw_bypass_op1", obs_op1, 32'h1234);
`else
    chk("raw_wb_cycle_valid", obs_valid, 4'b0000);
    cycle(R);
    chk("raw_after_wb_valid", obs_valid, 4'b0001);
    chk("raw_after_wb_op1", obs_op1, 32'h1234);
`endif

    // Backpressure on an LSU store, followed by an rd=x0 ALU op
    iq.push_back(mk(1, 11, 4'b1110, 32'd8, 2, 3, 0, 0, 0, 32'h200, 32'h1fc));
    iq.push_back(mk(0, 3, 4'b1100, 32'd0, 2, 3, 0, 1, 0, 32'h204, 32'h200));
    cycle(R);
    repeat (5) begin
      cycle(4'b1101);
      chk("bp_valid", obs_valid, 4'b0010);
      chk("bp_ren", obs_ren, 1'b0);
      chk("bp_op1", obs_op1, 32'd22);
      chk("bp_imm", obs_imm, 32'd8);
    end
    cycle(R);
    chk("bp_fire_valid", obs_valid, 4'b0010);
    chk("bp_fire_ren", obs_ren, 1'b1);
    cycle(R);
    chk("rd0_valid", obs_valid, 4'b0001);
    chk("model_busy0", 32'(busy_m[0]), 32'd0);

    // Flush while a branch is held
    iq.push_back(mk(2, 12, 4'b1100, 32'd16, 2, 3, 0, 0, 1, 32'h310, 32'h300));
    iq.push_back(mk(3, 15, 4'b1000, 32'd0, 2, 0, 0, 0, 0, 32'h304, 32'h300));
    cycle(R);
    cycle(4'b1011);
    chk("flush_held_valid", obs_valid, 4'b0100);
    chk("flush_held_taken", obs_taken, 1'b1);
    cycle(R, 1'b1);
    chk("flush_valid", obs_valid, 4'b0000);
    chk("flush_ren", obs_ren, 1'b0);
    cycle(R);
    chk("post_flush_ren", obs_ren, 1'b1);
    chk("post_flush_valid", obs_valid, 4'b0000);
    cycle(R);
    chk("post_flush_csr_valid", obs_valid, 4'b1000);

    // Set/clear collision on x5
    iq.push_back(mk(0, 0, 4'b1100, 32'd0, 2, 3, 5, 1, 0, 32'h404, 32'h400));
    cycle(R);
    cycle(R, 1'b0, 1'b1, 5'd5, 32'h55aa);
    chk("coll_valid", obs_valid, 4'b0001);
    chk("model_busy5", 32'(busy_m[5]), 32'd1);
    iq.push_back(mk(0, 4, 4'b1100, 32'd0, 5, 2, 7, 1, 0, 32'h408, 32'h404));
    cycle(R);
    repeat (2) begin
      cycle(R);
      chk("coll_reader_held", obs_valid, 4'b0000);
    end
    cycle(R, 1'b0, 1'b1, 5'd5, 32'h77);
    cycle(R);

    // Asynchronous reset while holding a hazarded entry with busy bits set
    iq.push_back(mk(0, 0, 4'b1100, 32'd0, 2, 3, 9, 1, 0, 32'h504, 32'h500));
    iq.push_back(mk(0, 2, 4'b1100, 32'd0, 9, 2, 10, 1, 0, 32'h508, 32'h504));
    cycle(R);
    cycle(R);
    cycle(R);
    chk("rst_pre_held", obs_valid, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    iq.push_back(mk(0, 2, 4'b1100, 32'd0, 9, 2, 10, 1, 0, 32'h508, 32'h504));
    cycle(R);
    cycle(R);
    chk("post_rst_dispatch", obs_valid, 4'b0001);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (iq.size() < 3 && $urandom_range(0, 3) != 0) iq.push_back(rand_entry());
      for (int b = 0; b < 4; b++) rdy[b] = ($urandom_range(0, 3) != 0);
      cand.delete();
      for (int r = 1; r < 32; r++) if (busy_m[r]) cand.push_back(r);
      wbv = 1'b0;
      wbr = 5'd0;
      if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
        wbv = 1'b1;
        wbr = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      cycle(rdy, ($urandom_range(0, 19) == 0), wbv, wbr, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, async active-low reset).
REQ-002 The block SHALL have the parameters ISSUE_Q_WIDTH (default 123, entry width), DATA_WIDTH (default 32, operand width) and ADDR_WIDTH (default 32, PC width).
REQ-003 The issue-queue read side SHALL be: issue_q_rok (in, 1, entry available); issue_q_ren (out, 1, pop); issue_q_rdata (in, 123, entry).
REQ-004 The register-file read side SHALL be: rf_rs1_addr and rf_rs2_addr (out, 5); rf_rs1_data and rf_rs2_data (in, 32, combinational read).
REQ-005 The dispatch side SHALL be: disp_valid (out, 4, one-hot per FU: bit0 ALU, bit1 LSU, bit2 BPU, bit3 CSR); disp_ready (in, 4); disp_operator (out, 4); disp_op1, disp_op2 and disp_imm (out, 32); disp_rd (out, 5); disp_rd_wen (out, 1); disp_cur_pc and disp_nxt_pc (out, 32); disp_taken (out, 1).
REQ-006 The writeback and control side SHALL be: wb_valid (in, 1); wb_rd (in, 5); wb_data (in, 32); flush (in, 1, kill the staged entry).

Function
REQ-007 Entry fields (LSB first) SHALL be: function[1:0], operator[5:2], operand[9:6], imm[41:10], rs1[46:42], rs2[51:47], rd[56:52], rd_wen[57], taken[58], nxt_pc[90:59], cur_pc[122:91].
REQ-008 Operand-select bits SHALL be: operand[3] use rs1; operand[2] use rs2; operand[1] use imm; operand[0] use pc.
REQ-009 The block SHALL hold one staged entry; its FSM states SHALL be EMPTY and HELD.
REQ-010 issue_q_ren SHALL be ~flush & (state==EMPTY | fire), where fire = |(disp_valid & disp_ready); a pop occurs when issue_q_ren & issue_q_rok.
REQ-011 FSM transitions:
- EMPTY to HELD on pop.
- HELD to HELD on fire with a pop.
- HELD to EMPTY on fire without a pop.
- HELD or EMPTY to EMPTY on flush; flush overrides pop and fire, with no pop and no busy-bit set.
REQ-012 Hazard SHALL be (operand[3] & busy[rs1]) | (operand[2] & busy[rs2]) | (rd_wen & busy[rd]); busy[0] SHALL read 0.
REQ-013 disp_valid[function] SHALL be asserted iff state==HELD & ~hazard & ~flush; once asserted it SHALL remain asserted with a stable payload until fire or flush.
REQ-014 Operand selection:
- disp_op1 = operand[3] ? rf_rs1_data : operand[0] ? cur_pc : 0.
- disp_op2 = operand[2] ? rf_rs2_data : operand[1] ? imm : 0.
- rf_rsX_addr SHALL come from the staged entry.
REQ-015 On fire with rd_wen & rd!=0, busy[rd] SHALL be set; on wb_valid & wb_rd!=0, busy[wb_rd] SHALL be cleared; a set and a clear of the same register in one cycle SHALL resolve as set.
REQ-016 Minimum latency SHALL be 1 cycle: an entry popped at edge N is dispatchable in cycle N+1, giving a throughput of one entry per cycle with no hazards.
REQ-017 A clear occurring in the same cycle as a hazard check SHALL take effect the following cycle (without the REQ-021 option).

Reset
REQ-018 Reset SHALL give: state=EMPTY; busy=0; disp_valid=0; issue_q_ren=1 (EMPTY); and all payload outputs 0.
REQ-019 Reset asserted mid-operation SHALL discard the staged entry and all busy bits immediately and asynchronously.

Configuration
REQ-020 The macro ISSUE_UNIT_WB_BYPASS_EN SHALL be the sole configuration option.
REQ-021 With ISSUE_UNIT_WB_BYPASS_EN defined:
- A same-cycle wb_valid for register r SHALL be treated as not busy for the hazard check.
- wb_data SHALL be forwarded to disp_op1/disp_op2 when rs1/rs2 == wb_rd != 0.
REQ-022 Without ISSUE_UNIT_WB_BYPASS_EN, wb_data SHALL be unused and REQ-017 SHALL apply.

Structure
REQ-023 A shared package SHALL hold: the FU codes, operator codes, operand-bit positions, entry field offsets/widths and ISSUE_Q_WIDTH.
REQ-024 A single sub-module, issue_scoreboard, SHALL own the 32 busy bits with set/clear/lookup ports; all other logic SHALL stay in issue_unit.

Verification
REQ-025 The bench SHALL cover the following scenarios:
- Back-to-back independent ops: add x1=x2+x3, then addi x4=x5+7, with all disp_ready=1 -> ALU dispatch on consecutive cycles; op2 of the second equals 7.
- RAW hazard: add x1, then sub x6=x1-x2 -> sub is held; disp_valid stays 0 until wb_valid with wb_rd=1; it dispatches the next cycle (the same cycle with the macro, op1 equal to wb_data).
- Backpressure: LSU store with disp_ready[1]=0 for 5 cycles -> disp_valid[1] and payload stay stable and issue_q_ren=0; fire occurs on ready.
- Flush while HELD: beq held, flush=1 -> disp_valid=0, no pop that cycle, state EMPTY, busy unchanged.
- Set/clear collision: dispatch of rd=5 while wb_valid with wb_rd=5 -> busy[5] stays 1; rd=0 dispatch -> busy unchanged.
- Reset mid-hold: assert rst_n=0 with busy nonzero -> all outputs at reset values within the reset cycle.
